// File: rtl/tx_scrambler_serializer_if.sv
// Code-group handshake between the 4B/5B PCS encoder (master) and the
// transmit scrambler/serializer (slave).
interface tx_scrambler_serializer_if;
  logic [4:0] code_group;
  logic       code_valid;
  logic       code_ready;

  modport master (
    output code_group,
    output code_valid,
    input  code_ready
  );

  modport slave (
    input  code_group,
    input  code_valid,
    output code_ready
  );
endinterface

// File: rtl/tx_scrambler_serializer.sv
// 100BASE-TX transmit stage: 5-bit code-group serializer (MSB first) with
// x^11 + x^9 + 1 stream scrambler and IDLE insertion on PCS underrun.
module tx_scrambler_serializer #(
  parameter logic [10:0] SEED        = 11'h7FF,
  parameter bit          SCRAMBLE_EN = 1'b1,
  parameter logic [4:0]  IDLE_CODE   = 5'b11111
) (
  input  logic                            clock,
  input  logic                            reset,
  tx_scrambler_serializer_if.slave        pcs,
  output logic                            NRZ,
  output logic                            symbol_start,
  output logic                            idle_inserted,
  output logic [10:0]                     lfsr_state
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [10:0] SEED_EFF = (SEED == 11'd0) ? 11'h001 : SEED;

  logic [4:0]  shreg_reg;
  logic [2:0]  bit_cnt_reg;
  logic [10:0] lfsr_reg;
  logic [10:0] lfsr_next;
  logic        load_slot;
  logic        key;

  // Counts 5-7 cannot occur normally; treating them as the load slot
  // guarantees the counter falls back into range on the next edge.
  assign load_slot = (bit_cnt_reg >= 3'd4);
  assign key       = lfsr_reg[10] ^ lfsr_reg[8];

  generate
    for (genvar gi = 1; gi < 11; gi++) begin : g_lfsr_shift
      assign lfsr_next[gi] = lfsr_reg[gi-1];
    end
  endgenerate
  assign lfsr_next[0] = key;

  assign pcs.code_ready = load_slot && !reset;
  assign lfsr_state     = lfsr_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      shreg_reg     <= IDLE_CODE;
      bit_cnt_reg   <= 3'd0;
      lfsr_reg      <= SEED_EFF;
      NRZ           <= 1'b0;
      symbol_start  <= 1'b0;
      idle_inserted <= 1'b0;
    end else begin
      lfsr_reg      <= lfsr_next;
      NRZ           <= shreg_reg[4] ^ (SCRAMBLE_EN ? key : 1'b0);
      symbol_start  <= (bit_cnt_reg == 3'd0);
      idle_inserted <= load_slot && !pcs.code_valid;
      if (load_slot) begin
        shreg_reg   <= pcs.code_valid ? pcs.code_group : IDLE_CODE;
        bit_cnt_reg <= 3'd0;
      end else begin
        shreg_reg   <= {shreg_reg[3:0], 1'b0};
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
      end
    end
  end

endmodule
